axi_write_arbiter: RTL and testbench



---
 rtl/axi_pkg.sv | 29 ++
 rtl/rr_arbiter_2.sv | 35 +++
 rtl/axi_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants, response codes and write-arbiter state encoding.
// Imported by the write arbiter and its round-robin grant helper.
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MID_W  = 4;
    localparam int SID_W  = 2 * MID_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } wr_state_e;

    // One-hot two-way grant to master index.
    function automatic logic grant_idx(input logic [1:0] i_onehot);
        return i_onehot[1];
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant with an internal priority pointer.
// The pointer moves to the requester not served when i_done pulses.
module rr_arbiter_2 (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] i_req,
    input  logic       i_done,
    input  logic       i_served,
    output logic [1:0] o_grant
);
    import axi_pkg::*;

    logic r_ptr;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_ptr <= M0;
        end else if (i_done) begin
            r_ptr <= ~i_served;
        end
    end

    // NOTE: default first so every path assigns o_grant and no latch appears.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Two-master AXI4 write-path arbiter: one transaction at a time, round-robin.
// Optional response watchdog under `define AXI_ARB_TIMEOUT_EN.
module axi_write_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MID_W          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [MID_W-1:0]      AWID_M0,     AWID_M1,
    input  logic [ADDR_W-1:0]     AWADDR_M0,   AWADDR_M1,
    input  logic [3:0]            AWLEN_M0,    AWLEN_M1,
    input  logic [2:0]            AWSIZE_M0,   AWSIZE_M1,
    input  logic [1:0]            AWBURST_M0,  AWBURST_M1,
    input  logic                  AWVALID_M0,  AWVALID_M1,
    output logic                  AWREADY_M0,  AWREADY_M1,
    input  logic [DATA_W-1:0]     WDATA_M0,    WDATA_M1,
    input  logic [DATA_W/8-1:0]   WSTRB_M0,    WSTRB_M1,
    input  logic                  WLAST_M0,    WLAST_M1,
    input  logic                  WVALID_M0,   WVALID_M1,
    output logic                  WREADY_M0,   WREADY_M1,
    output logic [MID_W-1:0]      BID_M0,      BID_M1,
    output logic [1:0]            BRESP_M0,    BRESP_M1,
    output logic                  BVALID_M0,   BVALID_M1,
    input  logic                  BREADY_M0,   BREADY_M1,
    output logic [2*MID_W-1:0]    AWID_S,
    output logic [ADDR_W-1:0]     AWADDR_S,
    output logic [3:0]            AWLEN_S,
    output logic [2:0]            AWSIZE_S,
    output logic [1:0]            AWBURST_S,
    output logic                  AWVALID_S,
    input  logic                  AWREADY_S,
    output logic [DATA_W-1:0]     WDATA_S,
    output logic [DATA_W/8-1:0]   WSTRB_S,
    output logic                  WLAST_S,
    output logic                  WVALID_S,
    input  logic                  WREADY_S,
    input  logic [2*MID_W-1:0]    BID_S,
    input  logic [1:0]            BRESP_S,
    input  logic                  BVALID_S,
    output logic                  BREADY_S
);
    import axi_pkg::*;

    wr_state_e        r_state, w_state_nxt;
    logic             r_grant;
    logic [1:0]       w_req, w_rr_grant;
    logic             w_b_done, w_tmo;
    logic             w_g_awvalid, w_g_wvalid, w_g_wlast, w_g_bready;
    logic [MID_W-1:0] w_g_awid, w_b_idx;

    assign w_req       = {AWVALID_M1, AWVALID_M0};
    assign w_g_awid    = r_grant ? AWID_M1    : AWID_M0;
    assign w_g_awvalid = r_grant ? AWVALID_M1 : AWVALID_M0;
    assign w_g_wvalid  = r_grant ? WVALID_M1  : WVALID_M0;
    assign w_g_wlast   = r_grant ? WLAST_M1   : WLAST_M0;
    assign w_g_bready  = r_grant ? BREADY_M1  : BREADY_M0;
    assign w_b_idx     = BID_S[2*MID_W-1:MID_W];

    rr_arbiter_2 u_rr (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .i_req    (w_req),
        .i_done   (w_b_done),
        .i_served (r_grant),
        .o_grant  (w_rr_grant)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
            r_grant <= M0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && |w_req) r_grant <= grant_idx(w_rr_grant);
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo;
    logic [MID_W-1:0] r_awid;
    logic             w_active, w_tmo_hit, w_chan_hs, w_enter;

    assign w_active  = (r_state == ST_DATA) || (r_state == ST_RESP);
    assign w_tmo_hit = w_active && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
    assign w_tmo     = r_tmo | w_tmo_hit;
    assign w_chan_hs = (r_state == ST_DATA) ? (WVALID_S & WREADY_S) : (BVALID_S & BREADY_S);
    assign w_enter   = (w_state_nxt != r_state) &&
                       ((w_state_nxt == ST_DATA) || (w_state_nxt == ST_RESP));

    // Counter saturates at the limit; the sticky flag carries a DATA timeout into RESP.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
            r_awid    <= '0;
        end else begin
            if (w_enter || w_chan_hs)     r_tmo_cnt <= '0;
            else if (w_active && !w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_state_nxt == ST_IDLE)   r_tmo <= 1'b0;
            else if (w_tmo_hit)           r_tmo <= 1'b1;
            if (r_state == ST_ADDR && AWVALID_S && AWREADY_S) r_awid <= w_g_awid;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_b_done    = 1'b0;
        AWREADY_M0  = 1'b0;  AWREADY_M1 = 1'b0;
        WREADY_M0   = 1'b0;  WREADY_M1  = 1'b0;
        BID_M0      = '0;    BID_M1     = '0;
        BRESP_M0    = '0;    BRESP_M1   = '0;
        BVALID_M0   = 1'b0;  BVALID_M1  = 1'b0;
        AWID_S      = '0;    AWADDR_S   = '0;
        AWLEN_S     = '0;    AWSIZE_S   = '0;
        AWBURST_S   = '0;    AWVALID_S  = 1'b0;
        WDATA_S     = '0;    WSTRB_S    = '0;
        WLAST_S     = 1'b0;  WVALID_S   = 1'b0;
        BREADY_S    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                AWID_S    = {MID_W'(r_grant), w_g_awid};
                AWADDR_S  = r_grant ? AWADDR_M1  : AWADDR_M0;
                AWLEN_S   = r_grant ? AWLEN_M1   : AWLEN_M0;
                AWSIZE_S  = r_grant ? AWSIZE_M1  : AWSIZE_M0;
                AWBURST_S = r_grant ? AWBURST_M1 : AWBURST_M0;
                AWVALID_S = w_g_awvalid;
                if (r_grant) AWREADY_M1 = AWREADY_S;
                else         AWREADY_M0 = AWREADY_S;
                if (w_g_awvalid && AWREADY_S) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                // After a timeout the slave is bypassed and the master's beats are drained.
                WDATA_S  = r_grant ? WDATA_M1 : WDATA_M0;
                WSTRB_S  = r_grant ? WSTRB_M1 : WSTRB_M0;
                WLAST_S  = w_g_wlast;
                WVALID_S = w_g_wvalid & ~w_tmo;
                if (r_grant) WREADY_M1 = w_tmo | WREADY_S;
                else         WREADY_M0 = w_tmo | WREADY_S;
                if (w_g_wvalid && (w_tmo || WREADY_S) && w_g_wlast) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_b_idx == MID_W'(0)) begin
                    BREADY_S  = BREADY_M0;
                    BVALID_M0 = BVALID_S;
                    BID_M0    = BID_S[MID_W-1:0];
                    BRESP_M0  = BRESP_S;
                end else if (w_b_idx == MID_W'(1)) begin
                    BREADY_S  = BREADY_M1;
                    BVALID_M1 = BVALID_S;
                    BID_M1    = BID_S[MID_W-1:0];
                    BRESP_M1  = BRESP_S;
                end else begin
                    BREADY_S  = 1'b1;
                end
                if (BVALID_S && BREADY_S) begin
                    w_state_nxt = ST_IDLE;
                    w_b_done    = 1'b1;
                end
`ifdef AXI_ARB_TIMEOUT_EN
                if (w_tmo) begin
                    BREADY_S  = 1'b0;
                    BVALID_M0 = 1'b0;  BVALID_M1 = 1'b0;
                    BID_M0    = '0;    BID_M1    = '0;
                    BRESP_M0  = '0;    BRESP_M1  = '0;
                    if (r_grant) begin
                        BVALID_M1 = 1'b1;  BID_M1 = r_awid;  BRESP_M1 = RESP_SLVERR;
                    end else begin
                        BVALID_M0 = 1'b1;  BID_M0 = r_awid;  BRESP_M0 = RESP_SLVERR;
                    end
                    w_state_nxt = w_g_bready ? ST_IDLE : ST_RESP;
                    w_b_done    = w_g_bready;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed, scoreboard-driven bench for axi_write_arbiter.
// Transactions are queued at issue time and checked as the DUT forwards them.
module tb_axi_write_arbiter;
    import axi_pkg::*;

    localparam int TMO = 16;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [3:0]  awid_m [2];
    logic [31:0] awaddr_m [2];
    logic [3:0]  awlen_m [2];
    logic [2:0]  awsize_m [2];
    logic [1:0]  awburst_m [2];
    logic        awvalid_m [2], awready_m [2];
    logic [31:0] wdata_m [2];
    logic [3:0]  wstrb_m [2];
    logic        wlast_m [2], wvalid_m [2], wready_m [2];
    logic [3:0]  bid_m [2];
    logic [1:0]  bresp_m [2];
    logic        bvalid_m [2], bready_m [2];

    logic [7:0]  awid_s, bid_s;
    logic [31:0] awaddr_s, wdata_s;
    logic [3:0]  awlen_s, wstrb_s;
    logic [2:0]  awsize_s;
    logic [1:0]  awburst_s, bresp_s;
    logic        awvalid_s, awready_s, wlast_s, wvalid_s, wready_s, bvalid_s, bready_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [31:0] addr;
        int          len;
        logic [1:0]  resp;
    } txn_t;
    txn_t sb_q[$];

    axi_write_arbiter #(.ADDR_W(32), .DATA_W(32), .MID_W(4), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID_M0(awid_m[0]), .AWID_M1(awid_m[1]),
        .AWADDR_M0(awaddr_m[0]), .AWADDR_M1(awaddr_m[1]),
        .AWLEN_M0(awlen_m[0]), .AWLEN_M1(awlen_m[1]),
        .AWSIZE_M0(awsize_m[0]), .AWSIZE_M1(awsize_m[1]),
        .AWBURST_M0(awburst_m[0]), .AWBURST_M1(awburst_m[1]),
        .AWVALID_M0(awvalid_m[0]), .AWVALID_M1(awvalid_m[1]),
        .AWREADY_M0(awready_m[0]), .AWREADY_M1(awready_m[1]),
        .WDATA_M0(wdata_m[0]), .WDATA_M1(wdata_m[1]),
        .WSTRB_M0(wstrb_m[0]), .WSTRB_M1(wstrb_m[1]),
        .WLAST_M0(wlast_m[0]), .WLAST_M1(wlast_m[1]),
        .WVALID_M0(wvalid_m[0]), .WVALID_M1(wvalid_m[1]),
        .WREADY_M0(wready_m[0]), .WREADY_M1(wready_m[1]),
        .BID_M0(bid_m[0]), .BID_M1(bid_m[1]),
        .BRESP_M0(bresp_m[0]), .BRESP_M1(bresp_m[1]),
        .BVALID_M0(bvalid_m[0]), .BVALID_M1(bvalid_m[1]),
        .BREADY_M0(bready_m[0]), .BREADY_M1(bready_m[1]),
        .AWID_S(awid_s), .AWADDR_S(awaddr_s), .AWLEN_S(awlen_s), .AWSIZE_S(awsize_s),
        .AWBURST_S(awburst_s), .AWVALID_S(awvalid_s), .AWREADY_S(awready_s),
        .WDATA_S(wdata_s), .WSTRB_S(wstrb_s), .WLAST_S(wlast_s), .WVALID_S(wvalid_s),
        .WREADY_S(wready_s),
        .BID_S(bid_s), .BRESP_S(bresp_s), .BVALID_S(bvalid_s), .BREADY_S(bready_s)
    );

    logic any_out;
    always_comb begin
        any_out = |{awready_m[0], awready_m[1], wready_m[0], wready_m[1],
                    bvalid_m[0], bvalid_m[1], bid_m[0], bid_m[1], bresp_m[0], bresp_m[1],
                    awid_s, awaddr_s, awlen_s, awsize_s, awburst_s, awvalid_s,
                    wdata_s, wstrb_s, wlast_s, wvalid_s, bready_s};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int m = 0; m < 2; m++) begin
            awid_m[m] = '0; awaddr_m[m] = '0; awlen_m[m] = '0; awsize_m[m] = '0;
            awburst_m[m] = '0; awvalid_m[m] = 1'b0; wdata_m[m] = '0; wstrb_m[m] = '0;
            wlast_m[m] = 1'b0; wvalid_m[m] = 1'b0; bready_m[m] = 1'b0;
        end
        awready_s = 1'b0; wready_s = 1'b0; bid_s = '0; bresp_s = '0; bvalid_s = 1'b0;
    endtask

    task automatic issue(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input int len, input logic [1:0] resp);
        txn_t t;
        t.m = m; t.id = id; t.addr = addr; t.len = len; t.resp = resp;
        sb_q.push_back(t);
        awvalid_m[m] = 1'b1; awid_m[m] = id; awaddr_m[m] = addr;
        awlen_m[m] = 4'(len); awsize_m[m] = 3'd2; awburst_m[m] = 2'b01;
    endtask

    // Plays slave and granted master for the oldest queued transaction.
    task automatic serve_one(input bit toggle, input bit bad_bid);
        txn_t t;
        int   o, hs, beat;
        bit   found, other_seen;
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        t = sb_q.pop_front();
        o = 1 - t.m;
        found = 1'b0;
        other_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            other_seen |= awready_m[o] | wready_m[o] | bvalid_m[o];
            if (awvalid_s) begin
                found = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        check("aw_granted", found, 1);
        if (!found) return;
        check("awid_s", awid_s, {4'(t.m), t.id});
        check("awaddr_s", awaddr_s, t.addr);
        check("awlen_s", awlen_s, 4'(t.len));
        awready_s = 1'b1;
        #1;
        check("awready_mg", awready_m[t.m], 1);
        other_seen |= awready_m[o];
        @(negedge ACLK);
        awvalid_m[t.m] = 1'b0;
        awready_s = 1'b0;

        hs = 0; beat = 0;
        wready_s = !toggle;
        wvalid_m[t.m] = 1'b1; wstrb_m[t.m] = 4'hF;
        wdata_m[t.m] = t.addr; wlast_m[t.m] = (t.len == 0);
        for (int c = 0; c < 60 && beat <= t.len; c++) begin
            #1;
            other_seen |= awready_m[o] | wready_m[o] | bvalid_m[o];
            if (wvalid_s && wready_s) begin
                hs++;
                check("wdata_s", wdata_s, t.addr + 32'(beat));
                check("wlast_s", wlast_s, beat == t.len);
                check("wready_mg", wready_m[t.m], 1);
                beat++;
            end
            @(negedge ACLK);
            if (toggle) wready_s = !wready_s;
            wdata_m[t.m] = t.addr + 32'(beat);
            wlast_m[t.m] = (beat == t.len);
            if (beat > t.len) wvalid_m[t.m] = 1'b0;
        end
        check("w_beats", hs, t.len + 1);
        wvalid_m[t.m] = 1'b0; wlast_m[t.m] = 1'b0; wready_s = 1'b0;

        bvalid_s = 1'b1;
        bid_s = {bad_bid ? 4'h2 : 4'(t.m), t.id};
        bresp_s = t.resp;
        bready_m[0] = 1'b1; bready_m[1] = 1'b1;
        #1;
        check("bready_s", bready_s, 1);
        if (bad_bid) begin
            check("b_dropped", {bvalid_m[0], bvalid_m[1]}, 2'b00);
        end else begin
            check("bvalid_mg", bvalid_m[t.m], 1);
            check("bid_mg", bid_m[t.m], t.id);
            check("bresp_mg", bresp_m[t.m], t.resp);
            other_seen |= bvalid_m[o];
        end
        check("other_quiet", other_seen, 0);
        @(negedge ACLK);
        bvalid_s = 1'b0; bid_s = '0; bresp_s = '0;
        bready_m[0] = 1'b0; bready_m[1] = 1'b0;
        #1;
        check("b_done", bvalid_m[t.m], 0);
    endtask

    initial begin
        bit found;
        int wait_n;
        clear_inputs();
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        #1 check("reset_outputs", any_out, 0);
        ARESETn = 1'b1;
        #1 check("idle_outputs", any_out, 0);

        // Simultaneous requests twice: M0 first each round.
        @(negedge ACLK);
        issue(0, 4'h1, 32'h0000_1000, 0, RESP_OKAY);
        issue(1, 4'h4, 32'h0000_2000, 0, RESP_OKAY);
        serve_one(1'b0, 1'b0);
        serve_one(1'b0, 1'b0);
        @(negedge ACLK);
        issue(0, 4'h2, 32'h0000_1100, 0, RESP_OKAY);
        issue(1, 4'h5, 32'h0000_2100, 0, RESP_OKAY);
        serve_one(1'b0, 1'b0);
        serve_one(1'b0, 1'b0);

        // M0 single beat, AWID 3.
        @(negedge ACLK);
        issue(0, 4'h3, 32'h0000_0040, 0, RESP_OKAY);
        serve_one(1'b0, 1'b0);

        // M0 granted alone, M1 raises AWVALID while M0 is in flight.
        @(negedge ACLK);
        issue(0, 4'h6, 32'h0000_0080, 1, RESP_OKAY);
        @(negedge ACLK);
        issue(1, 4'hC, 32'h0000_00C0, 0, RESP_SLVERR);
        serve_one(1'b0, 1'b0);
        serve_one(1'b0, 1'b0);

        // M1 4-beat burst with WREADY_S toggling.
        @(negedge ACLK);
        issue(1, 4'hA, 32'h0000_3000, 3, RESP_OKAY);
        serve_one(1'b1, 1'b0);

        // Response whose BID decodes to no master is dropped.
        @(negedge ACLK);
        issue(0, 4'h5, 32'h0000_4000, 1, RESP_OKAY);
        serve_one(1'b0, 1'b1);

        // Reset in DATA, then a fresh M1 request.
        @(negedge ACLK);
        awvalid_m[0] = 1'b1; awid_m[0] = 4'h7; awaddr_m[0] = 32'h0000_5000; awlen_m[0] = 4'd1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (awvalid_s) begin
                found = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        check("rst_aw_granted", found, 1);
        awready_s = 1'b1;
        @(negedge ACLK);
        awvalid_m[0] = 1'b0; awready_s = 1'b0;
        wvalid_m[0] = 1'b1; wdata_m[0] = 32'hDEAD_0000; wlast_m[0] = 1'b0; wready_s = 1'b1;
        #1;
        check("rst_in_data", wready_m[0], 1);
        check("rst_wvalid_fwd", wvalid_s, 1);
        ARESETn = 1'b0;
        #1 check("rst_mid_outputs", any_out, 0);
        @(negedge ACLK);
        clear_inputs();
        ARESETn = 1'b1;
        #1 check("rst_release_idle", any_out, 0);
        issue(1, 4'h2, 32'h0000_6000, 0, RESP_OKAY);
        serve_one(1'b0, 1'b0);

`ifdef AXI_ARB_TIMEOUT_EN
        begin
            txn_t t;
            @(negedge ACLK);
            issue(0, 4'h9, 32'h0000_7000, 0, RESP_OKAY);
            t = sb_q.pop_front();
            found = 1'b0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (awvalid_s) begin
                    found = 1'b1;
                    break;
                end
                @(negedge ACLK);
            end
            check("tmo_aw_granted", found, 1);
            awready_s = 1'b1;
            @(negedge ACLK);
            awvalid_m[0] = 1'b0; awready_s = 1'b0;
            wvalid_m[0] = 1'b1; wlast_m[0] = 1'b1; wready_s = 1'b1;
            @(negedge ACLK);
            wvalid_m[0] = 1'b0; wlast_m[0] = 1'b0; wready_s = 1'b0;
            bready_m[0] = 1'b1;
            wait_n = -1;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (bvalid_m[0]) begin
                    wait_n = i;
                    break;
                end
                @(negedge ACLK);
            end
            check("tmo_cycles", wait_n, TMO);
            check("tmo_bresp", bresp_m[0], RESP_SLVERR);
            check("tmo_bid", bid_m[0], t.id);
            @(negedge ACLK);
            bready_m[0] = 1'b0;
            #1 check("tmo_b_done", bvalid_m[0], 0);
        end
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
